counter_updown_modulo: RTL

- Parametrised successor to the team's fixed-modulus up counter.
- Adds up/down direction, a run-time limit, synchronous parallel load, one-shot (halt-at-terminal) mode and a registered wrap pulse for cascading.
- Used as a general timebase/index generator feeding FSMs and display multiplexers; chains by tying a downstream enable to an upstream wrap.

---
 rtl/counter_pkg.sv | 26 ++
 rtl/counter_updown_modulo.sv | 100 ++++++++++
 2 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the up/down modulo counter: FSM state encoding,
// direction constants and the width helper used for the default NBITS.
package counter_pkg;

  typedef enum logic {
    COUNTING = 1'b0,
    HALTED   = 1'b1
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Smallest width able to hold values 0..value-1; never less than 1 bit.
  function automatic int unsigned CeilLog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result++;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/counter_updown_modulo.sv
// Up/down modulo counter with run-time limit, synchronous parallel load,
// one-shot halt-at-terminal mode and a registered wrap pulse for cascading.
module counter_updown_modulo
  import counter_pkg::*;
#(
  parameter int unsigned MAX_MODULUS = 16,
  parameter int unsigned NBITS       = CeilLog2(MAX_MODULUS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [NBITS-1:0] load_value,
  input  logic [NBITS-1:0] limit,
  input  logic             one_shot,
  output logic [NBITS-1:0] counter,
  output logic             flag,
  output logic             wrap,
  output logic             done
);

  localparam logic [NBITS-1:0] TOP_VALUE = NBITS'(MAX_MODULUS - 1);

  state_e           state_q, state_d;
  logic [NBITS-1:0] counter_q, counter_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic [NBITS-1:0] limit_eff;
  logic             terminal;

  // Keep the count inside 0..MAX_MODULUS-1 even when the limit port is wider
  // than the modulus needs; a power-of-two modulus needs no clamp at all.
  generate
    if ((64'd1 << NBITS) > 64'(MAX_MODULUS)) begin : g_limit_clamp
      always_comb limit_eff = (limit > TOP_VALUE) ? TOP_VALUE : limit;
    end else begin : g_limit_pass
      always_comb limit_eff = limit;
    end
  endgenerate

  // Terminal condition for the current direction; >= lets a shrinking limit
  // make the next up-step terminal immediately.
  always_comb begin
    if (up_down == DIR_UP) begin
      terminal = (counter_q >= limit_eff);
    end else begin
      terminal = (counter_q == '0);
    end
  end

  // Next-state logic: load beats enable; HALTED ignores enable entirely.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    wrap_d    = 1'b0;
    done_d    = done_q;
    if (load) begin
      counter_d = (load_value > limit_eff) ? limit_eff : load_value;
      state_d   = COUNTING;
      done_d    = 1'b0;
    end else if (state_q == COUNTING && enable) begin
      if (!terminal) begin
        if (up_down == DIR_UP) begin
          counter_d = counter_q + 1'b1;
        end else begin
          counter_d = counter_q - 1'b1;
        end
      end else if (one_shot) begin
        state_d = HALTED;
        done_d  = 1'b1;
        wrap_d  = 1'b1;
      end else begin
        counter_d = (up_down == DIR_UP) ? '0 : limit_eff;
        wrap_d    = 1'b1;
      end
    end
  end

  // State, count and registered status outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= COUNTING;
      counter_q <= '0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
    end
  end

  assign counter = counter_q;
  assign flag    = terminal;
  assign wrap    = wrap_q;
  assign done    = done_q;

endmodule
